// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host transmit path and its neighbours.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    BITS,
    ACK,
    WAIT_IDLE,
    ERROR
  } state_e;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
    return (clk_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 line plus a falling-edge strobe.
// The strobe is valid two cycles after the pin edge, so a consumer acts on it at the third.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving both lines open-drain via output enables.
// One byte in flight at a time; tx_ready is low for the whole transaction and nothing is queued.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ       = 100_000_000,
  parameter int unsigned INHIBIT_US        = 120,
  parameter int unsigned START_TIMEOUT_US  = 15_000,
  parameter int unsigned PACKET_TIMEOUT_US = 2_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned INH  = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
  localparam int unsigned STO  = us_to_cycles(CLK_FREQ_HZ, START_TIMEOUT_US);
  localparam int unsigned PTO  = us_to_cycles(CLK_FREQ_HZ, PACKET_TIMEOUT_US);
  localparam int unsigned MAXC = (INH > STO) ? ((INH > PTO) ? INH : PTO)
                                             : ((STO > PTO) ? STO : PTO);
  localparam int CW = $clog2(MAXC);

  logic clk_lvl;
  logic clk_fe;
  logic data_lvl;
  logic data_fe_unused;

  ps2_sync_edge u_clk_sync (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (ps2_clk_in),
    .level_o (clk_lvl),
    .fall_o  (clk_fe)
  );

  ps2_sync_edge u_data_sync (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (ps2_data_in),
    .level_o (data_lvl),
    .fall_o  (data_fe_unused)
  );

  state_e        state_q;
  logic [8:0]    shift_q;
  logic [3:0]    bit_idx_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] pkt_q;
  logic          clk_oe_q;
  logic          data_oe_q;
  logic          done_q;
  logic          err_q;

  logic accept;
  logic pkt_expired;

  assign accept      = tx_valid && (state_q == IDLE);
  assign pkt_expired = (pkt_q == CW'(PTO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      pkt_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q   <= {odd_parity(tx_data), tx_data};
            cnt_q     <= '0;
            clk_oe_q  <= 1'b1;
            data_oe_q <= 1'b0;
            state_q   <= INHIBIT;
          end
        end
        INHIBIT: begin
          cnt_q <= cnt_q + 1'b1;
          // Start bit goes low one cycle before the clock is released.
          if (cnt_q == CW'(INH - 2)) data_oe_q <= 1'b1;
          if (cnt_q == CW'(INH - 1)) begin
            clk_oe_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (clk_fe) begin
            // First device edge already asks for D0.
            data_oe_q <= ~shift_q[0];
            shift_q   <= {1'b0, shift_q[8:1]};
            bit_idx_q <= '0;
            pkt_q     <= '0;
            state_q   <= BITS;
          end else if (cnt_q == CW'(STO - 1)) begin
            data_oe_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= ERROR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BITS: begin
          pkt_q <= pkt_q + 1'b1;
          if (pkt_expired) begin
            data_oe_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= ERROR;
          end else if (clk_fe) begin
            if (bit_idx_q == 4'd8) begin
              data_oe_q <= 1'b0;
              state_q   <= ACK;
            end else begin
              data_oe_q <= ~shift_q[0];
              shift_q   <= {1'b0, shift_q[8:1]};
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        ACK: begin
          pkt_q <= pkt_q + 1'b1;
          if (pkt_expired || (clk_fe && data_lvl)) begin
            err_q   <= 1'b1;
            state_q <= ERROR;
          end else if (clk_fe) begin
            state_q <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          pkt_q <= pkt_q + 1'b1;
          if (pkt_expired) begin
            err_q   <= 1'b1;
            state_q <= ERROR;
          end else if (clk_lvl && data_lvl) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        ERROR: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_error    = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on wired-AND lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int unsigned INH = 120;   // 10 MHz * 12 us
  localparam int unsigned STO = 2000;  // 10 MHz * 200 us
  localparam int unsigned PTO = 3000;  // 10 MHz * 300 us
  localparam int          HP  = 100;   // device half period in system cycles

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_error;
  logic       bfm_clk;
  logic       bfm_data;
  logic       clk_line;
  logic       data_line;

  assign clk_line  = bfm_clk & ~ps2_clk_oe;
  assign data_line = bfm_data & ~ps2_data_oe;

  ps2_host_tx #(
    .CLK_FREQ_HZ       (10_000_000),
    .INHIBIT_US        (12),
    .START_TIMEOUT_US  (200),
    .PACKET_TIMEOUT_US (300)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error)
  );

  always #50 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int oe_cycles = 0;
  int excl_cnt = 0;
  int err_cyc = 0;
  int req_cyc = 0;
  int fe1_cyc = 0;
  logic [1:0] err_oe = 2'b00;
  logic busy_after_err = 1'b0;
  logic err_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (err_prev) busy_after_err = busy;
    err_prev = tx_error;
    if (tx_done) done_cnt++;
    if (tx_error) begin
      err_cnt++;
      err_cyc = cyc;
      err_oe  = {ps2_clk_oe, ps2_data_oe};
    end
    if (tx_done && tx_error) excl_cnt++;
    if (ps2_clk_oe) oe_cycles++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~d;
  endtask

  // Device side: waits for the request-to-send, then clocks n_fe falling edges,
  // sampling host data on each rising edge; optionally pulls data low for the ack.
  task automatic device(input int n_fe, input bit ack, output logic [9:0] bits, output bit ok);
    int w;
    bits = '0;
    ok   = 1'b0;
    w    = 0;
    while (!(clk_line === 1'b1 && data_line === 1'b0) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) return;
    req_cyc = cyc;
    ok = 1'b1;
    repeat (HP) @(negedge clk);
    for (int i = 0; i < n_fe; i++) begin
      if (i == 10 && ack) begin
        bfm_data = 1'b0;
        repeat (10) @(negedge clk);
      end
      if (i == 0) fe1_cyc = cyc;
      bfm_clk = 1'b0;
      repeat (HP) @(negedge clk);
      bfm_clk = 1'b1;
      if (i < 10) bits[i] = data_line;
      repeat (HP) @(negedge clk);
    end
    bfm_data = 1'b1;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int w;
    w = 0;
    while (busy !== 1'b0 && w < limit) begin
      @(negedge clk);
      w++;
    end
    ok = (busy === 1'b0);
  endtask

  typedef struct {
    logic [7:0] data;
    int         n_fe;
    bit         ack;
    logic [9:0] bits;      // {stop, parity, D7..D0} as sampled by the device
    bit         exp_done;
    int         kind;      // 0 normal/nack, 1 start timeout, 2 packet timeout
  } vec_t;

  vec_t vecs [6];

  initial begin
    #8_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    logic [9:0] mask;
    bit         ok;
    bit         ok2;
    int         nb;

    vecs[0] = '{8'hF4, 11, 1'b1, 10'h2F4, 1'b1, 0};
    vecs[1] = '{8'hFF, 11, 1'b1, 10'h3FF, 1'b1, 0};
    vecs[2] = '{8'h00, 11, 1'b1, 10'h300, 1'b1, 0};
    vecs[3] = '{8'hAA, 11, 1'b0, 10'h3AA, 1'b0, 0};
    vecs[4] = '{8'h01, 0,  1'b1, 10'h201, 1'b0, 1};
    vecs[5] = '{8'h3C, 5,  1'b1, 10'h33C, 1'b0, 2};

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    bfm_clk  = 1'b1;
    bfm_data = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_data_oe", ps2_data_oe, 0);
    check("reset_tx_done", tx_done, 0);
    check("reset_tx_error", tx_error, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      @(posedge clk);
      done_cnt  = 0;
      err_cnt   = 0;
      oe_cycles = 0;
      check("ready_before_send", tx_ready, 1);
      send(vecs[v].data);
      check("busy_after_accept", busy, 1);
      check("ready_low_when_busy", tx_ready, 0);
      device(vecs[v].n_fe, vecs[v].ack, bits, ok);
      check("request_seen", ok, 1);
      wait_idle(5000, ok2);
      check("returns_idle", ok2, 1);
      repeat (5) @(negedge clk);
      if (vecs[v].n_fe > 0) begin
        nb   = (vecs[v].n_fe < 10) ? vecs[v].n_fe : 10;
        mask = 10'((11'h1 << nb) - 1);
        check("sampled_bits", bits & mask, vecs[v].bits & mask);
      end
      check("done_count", done_cnt, vecs[v].exp_done);
      check("error_count", err_cnt, !vecs[v].exp_done);
      check("inhibit_cycles", oe_cycles, INH);
      check("ready_after", tx_ready, 1);
      if (!vecs[v].exp_done) begin
        check("error_oe_released", err_oe, 0);
        check("busy_low_after_error", busy_after_err, 0);
      end
      if (vecs[v].kind == 1) check("start_timeout_cycles", err_cyc - req_cyc, STO);
      if (vecs[v].kind == 2) check("packet_timeout_cycles", err_cyc - fe1_cyc, PTO + 3);
    end

    // Async reset in the middle of the data bits.
    @(posedge clk);
    done_cnt = 0;
    err_cnt  = 0;
    send(8'hF4);
    device(4, 1'b1, bits, ok);
    check("rst_seq_request_seen", ok, 1);
    check("pre_reset_data_oe_d3", ps2_data_oe, 1);
    #10;
    rst = 1'b1;
    #1;
    check("midrst_clk_oe", ps2_clk_oe, 0);
    check("midrst_data_oe", ps2_data_oe, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", tx_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_no_done", done_cnt, 0);
    check("midrst_no_error", err_cnt, 0);

    // Clean send afterwards, with a stray request while busy.
    @(posedge clk);
    done_cnt  = 0;
    err_cnt   = 0;
    oe_cycles = 0;
    send(8'hF4);
    fork
      device(11, 1'b1, bits, ok);
      begin
        repeat (300) @(negedge clk);
        check("busy_during_stray_valid", busy, 1);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_idle(5000, ok2);
    check("post_rst_idle", ok2, 1);
    repeat (20) @(negedge clk);
    check("post_rst_bits", bits, 10'h2F4);
    check("post_rst_done", done_cnt, 1);
    check("post_rst_error", err_cnt, 0);
    check("post_rst_single_packet", oe_cycles, INH);
    check("done_error_exclusive", excl_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
